// File: rtl/lieat_exu_vpu_vwb.sv
// VPU writeback: captures a VPU result, writes its lanes to the VRF one per cycle, then commits.
// Optional macro LIEAT_VWB_MASKSKIP_EN skips lanes whose captured byte mask is all zero.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef REG_IDX
`define REG_IDX 5
`endif

module lieat_exu_vpu_vwb #(
    parameter int LANES = 8,
    parameter int MASKW = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                vpu_o_valid,
    output logic                vpu_o_ready,
    input  logic [`XLEN-1:0]    vpu_o_pc,
    input  logic                vpu_o_wen,
    input  logic [`REG_IDX-1:0] vpu_o_rd,
    input  logic [`XLEN-1:0]    vpu_o_data,
    input  logic                vpu_o_vwen,
    input  logic [`XLEN-1:0]    vpu_o_data0,
    input  logic [`XLEN-1:0]    vpu_o_data1,
    input  logic [`XLEN-1:0]    vpu_o_data2,
    input  logic [`XLEN-1:0]    vpu_o_data3,
    input  logic [`XLEN-1:0]    vpu_o_data4,
    input  logic [`XLEN-1:0]    vpu_o_data5,
    input  logic [`XLEN-1:0]    vpu_o_data6,
    input  logic [`XLEN-1:0]    vpu_o_data7,
    input  logic [MASKW-1:0]    vpu_o_mask0,
    input  logic [MASKW-1:0]    vpu_o_mask1,
    input  logic [MASKW-1:0]    vpu_o_mask2,
    input  logic [MASKW-1:0]    vpu_o_mask3,
    input  logic [MASKW-1:0]    vpu_o_mask4,
    input  logic [MASKW-1:0]    vpu_o_mask5,
    input  logic [MASKW-1:0]    vpu_o_mask6,
    input  logic [MASKW-1:0]    vpu_o_mask7,
    output logic                vrf_wen,
    output logic [`REG_IDX-1:0] vrf_rd,
    output logic [2:0]          vrf_lane,
    output logic [`XLEN-1:0]    vrf_data,
    output logic [MASKW-1:0]    vrf_mask,
    output logic                wb_valid,
    input  logic                wb_ready,
    output logic [`XLEN-1:0]    wb_pc,
    output logic                wb_wen,
    output logic [`REG_IDX-1:0] wb_rd,
    output logic [`XLEN-1:0]    wb_data
);
    localparam int XW = `XLEN;
    localparam int RW = `REG_IDX;

    typedef enum logic [1:0] {IDLE, VWR, CMT} state_e;

    state_e           state_q, state_d;
    logic [2:0]       lane_q, lane_d;
    logic [XW-1:0]    pc_q, data_q;
    logic             wen_q;
    logic [RW-1:0]    rd_q;
    logic [XW-1:0]    ldata_q [LANES];
    logic [MASKW-1:0] lmask_q [LANES];
    logic [7:0]       live_q;
    logic [XW-1:0]    ldata_in [LANES];
    logic [MASKW-1:0] lmask_in [LANES];
    logic [7:0]       live_in;
    logic             accept;
    logic [3:0]       first_in, next_q;

    // Lowest live lane at or above 'from', as {found, index}.
    function automatic logic [3:0] pick(input logic [7:0] live, input logic [3:0] from);
        logic [3:0] r;
        r = '0;
        for (int i = 7; i >= 0; i--)
            if (live[i] && 4'(i) >= from) r = {1'b1, 3'(i)};
        return r;
    endfunction

    always_comb begin
        ldata_in[0] = vpu_o_data0; lmask_in[0] = vpu_o_mask0;
        ldata_in[1] = vpu_o_data1; lmask_in[1] = vpu_o_mask1;
        ldata_in[2] = vpu_o_data2; lmask_in[2] = vpu_o_mask2;
        ldata_in[3] = vpu_o_data3; lmask_in[3] = vpu_o_mask3;
        ldata_in[4] = vpu_o_data4; lmask_in[4] = vpu_o_mask4;
        ldata_in[5] = vpu_o_data5; lmask_in[5] = vpu_o_mask5;
        ldata_in[6] = vpu_o_data6; lmask_in[6] = vpu_o_mask6;
        ldata_in[7] = vpu_o_data7; lmask_in[7] = vpu_o_mask7;
        live_in = 8'hFF;
`ifdef LIEAT_VWB_MASKSKIP_EN
        for (int i = 0; i < 8; i++) live_in[i] = |lmask_in[i];
`endif
    end

    assign accept = (state_q == IDLE) && vpu_o_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            lane_q  <= '0;
            pc_q    <= '0;
            data_q  <= '0;
            wen_q   <= 1'b0;
            rd_q    <= '0;
            live_q  <= '0;
            for (int i = 0; i < LANES; i++) begin
                ldata_q[i] <= '0;
                lmask_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            if (accept) begin
                pc_q   <= vpu_o_pc;
                data_q <= vpu_o_data;
                wen_q  <= vpu_o_wen;
                rd_q   <= vpu_o_rd;
                live_q <= live_in;
                for (int i = 0; i < LANES; i++) begin
                    ldata_q[i] <= ldata_in[i];
                    lmask_q[i] <= lmask_in[i];
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        first_in = pick(live_in, 4'd0);
        next_q   = pick(live_q, {1'b0, lane_q} + 4'd1);
        unique case (state_q)
            IDLE: if (accept) begin
                if (vpu_o_vwen && first_in[3]) begin
                    state_d = VWR;
                    lane_d  = first_in[2:0];
                end else begin
                    state_d = CMT;
                end
            end
            // Lane 7 yields no successor, so the pointer never wraps.
            VWR: if (next_q[3]) lane_d = next_q[2:0];
                 else state_d = CMT;
            CMT: if (wb_ready) begin
                state_d = IDLE;
                lane_d  = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        vpu_o_ready = (state_q == IDLE);
        vrf_wen     = 1'b0;
        vrf_rd      = '0;
        vrf_lane    = '0;
        vrf_data    = '0;
        vrf_mask    = '0;
        wb_valid    = 1'b0;
        wb_pc       = '0;
        wb_wen      = 1'b0;
        wb_rd       = '0;
        wb_data     = '0;
        unique case (state_q)
            VWR: begin
                vrf_wen  = 1'b1;
                vrf_rd   = rd_q;
                vrf_lane = lane_q;
                vrf_data = ldata_q[lane_q];
                vrf_mask = lmask_q[lane_q];
            end
            CMT: begin
                wb_valid = 1'b1;
                wb_pc    = pc_q;
                wb_wen   = wen_q;
                wb_rd    = rd_q;
                wb_data  = data_q;
            end
            default: ;
        endcase
    end
endmodule

// File: doc/lieat_exu_vpu_vwb.md
LIEAT_EXU_VPU_VWB -- requirements
Module: lieat_exu_vpu_vwb

Interface
REQ-001 The module SHALL take its widths from the global macros: XLEN is the lane/scalar data width, and REG_IDX is the register index width.
REQ-002 The module SHALL have parameter LANES, default 8, meaning the number of vector lanes per result.
REQ-003 The module SHALL have parameter MASKW, default 4, meaning the byte-enable bits per lane.
REQ-004 The module SHALL have port clock, input, 1, the single clock; every flop SHALL be clocked on its rising edge.
REQ-005 The module SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-006 The module SHALL have port vpu_o_valid, input, 1, meaning the upstream VPU result is valid.
REQ-007 The module SHALL have port vpu_o_ready, output, 1, meaning this block accepts the result.
REQ-008 The module SHALL have ports vpu_o_pc (XLEN), vpu_o_wen (1), vpu_o_rd (REG_IDX) and vpu_o_data (XLEN), all inputs, carrying the scalar result fields.
REQ-009 The module SHALL have ports vpu_o_vwen (1), vpu_o_data0..7 (XLEN each) and vpu_o_mask0..7 (MASKW each), all inputs, carrying the vector result fields.
REQ-010 The module SHALL have ports vrf_wen (1), vrf_rd (REG_IDX), vrf_lane (3), vrf_data (XLEN) and vrf_mask (MASKW), all outputs, forming the VRF write port; the VRF accepts every write with no backpressure.
REQ-011 The module SHALL have ports wb_valid (output, 1) and wb_ready (input, 1), the commit handshake.
REQ-012 The module SHALL have ports wb_pc (XLEN), wb_wen (1), wb_rd (REG_IDX) and wb_data (XLEN), all outputs, carrying the committed scalar fields.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, VWR and CMT.
REQ-014 vpu_o_ready SHALL be 1 only in IDLE; a result is accepted when vpu_o_valid and vpu_o_ready are both 1 on a rising clock edge.
REQ-015 On accept, all input fields SHALL be captured into internal registers; outputs SHALL be driven only from these registers, never combinationally from vpu_o_*.
REQ-016 On accept with vpu_o_vwen=0, the next state SHALL be CMT.
REQ-017 On accept with vpu_o_vwen=1, the next state SHALL be VWR, with the lane pointer set to the first lane to write.
REQ-018 In VWR, vrf_wen SHALL be 1, vrf_rd SHALL equal the captured rd, vrf_lane SHALL equal the lane pointer, and vrf_data and vrf_mask SHALL equal the captured lane data and mask.
REQ-019 In VWR, exactly one lane SHALL be written per cycle; after the last lane to write, the next state SHALL be CMT.
REQ-020 In CMT, wb_valid SHALL be 1 and wb_pc, wb_wen, wb_rd and wb_data SHALL equal the captured fields.
REQ-021 In CMT, when wb_ready=1 the next state SHALL be IDLE; otherwise the state SHALL hold and all wb_* outputs SHALL remain stable.
REQ-022 Outside VWR, vrf_wen SHALL be 0; outside CMT, wb_valid SHALL be 0.
REQ-023 Latency SHALL be as follows: for a scalar result accepted at edge N, wb_valid is 1 in cycle N+1; for a vector result writing K lanes, the writes occupy cycles N+1..N+K and wb_valid is 1 from cycle N+K+1.
REQ-024 Sustained throughput SHALL be at most one result per (2+K) cycles, since no new accept occurs before returning to IDLE.
REQ-025 The lane pointer SHALL be 3 bits and SHALL never wrap; lane 7 is always terminal.

Reset
REQ-026 While reset=1 at a rising edge, the state SHALL become IDLE, the lane pointer 0, and all captured registers 0.
REQ-027 Following reset, vpu_o_ready SHALL be 1 and all other outputs SHALL be 0.
REQ-028 A reset asserted mid-VWR or mid-CMT SHALL abandon the operation: no further VRF writes and no commit SHALL occur for it.

Configuration
REQ-029 With macro LIEAT_VWB_MASKSKIP_EN defined, lanes whose captured mask is 4'b0000 SHALL be skipped: the pointer SHALL jump to the next nonzero-mask lane, and a vector result with all masks zero SHALL go IDLE->CMT directly with zero VRF writes.
REQ-030 Without LIEAT_VWB_MASKSKIP_EN, all 8 lanes SHALL be written in order 0..7 (K=8), including lanes with a zero mask.

Verification
REQ-031 The bench SHALL cover: scalar result pc=0x80000010, wen=1, rd=5, data=0x1234, with wb_ready=1 -> wb_valid is 1 exactly in cycle N+1 with matching fields, and vrf_wen is never 1.
REQ-032 The bench SHALL cover: vector result rd=3, data_i=i+1, all masks 0xF -> vrf_lane 0..7 in cycles N+1..N+8 with vrf_data 1..8, then wb_valid in cycle N+9.
REQ-033 The bench SHALL cover, with LIEAT_VWB_MASKSKIP_EN: masks only lanes 2 and 6 nonzero -> exactly two writes, lane 2 then lane 6, then wb_valid in cycle N+3.
REQ-034 The bench SHALL cover: wb_ready held at 0 for 5 cycles in CMT -> wb_* stable, vpu_o_ready=0, and IDLE one cycle after wb_ready rises.
REQ-035 The bench SHALL cover: reset asserted during the vector write of lane 4 -> from the next cycle vrf_wen=0 and wb_valid=0, and vpu_o_ready=1.
REQ-036 The bench SHALL cover: back-to-back valid scalar results with wb_ready=1 -> one accept every 2 cycles, with no results lost or duplicated.
